decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter_if.sv | 25 ++
 rtl/decoder_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface decoder_rr_arbiter_if;
    logic [3:0] req;
    logic [1:0] grant_num;
    logic       grant_valid;
    logic [3:0] gnt;
    logic       preempt;

    modport master (
        output req,
        input  grant_num,
        input  grant_valid,
        input  gnt,
        input  preempt
    );

    modport slave (
        input  req,
        output grant_num,
        output grant_valid,
        output gnt,
        output preempt
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter. grant_num drives the 2-to-4 decoder select.
// A hold limit forces rotation when other requesters are waiting.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_rr_arbiter_if.slave bus_if
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] grant_num_q, grant_num_d;
    logic       grant_valid_q, grant_valid_d;
    logic [3:0] gnt_q, gnt_d;
    logic       preempt_q, preempt_d;

    logic [3:0] others;
    logic [1:0] winner;
    logic [1:0] winner_others;

    // First set bit of mask, searching upward from start with wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] result;
        logic [1:0] idx;
        logic       found;
        result = start;
        found  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // In GRANT the owner always equals last, so every search starts at last+1.
    assign others        = bus_if.req & ~(4'b0001 << grant_num_q);
    assign winner        = rr_pick(bus_if.req, last_q + 2'd1);
    assign winner_others = rr_pick(others, last_q + 2'd1);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        hold_cnt_d    = hold_cnt_q;
        grant_num_d   = grant_num_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus_if.req) begin
                    state_d       = GRANT;
                    grant_num_d   = winner;
                    last_d        = winner;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 8'd1;
                end
            end
            GRANT: begin
                if (!bus_if.req[grant_num_q]) begin
                    if (|others) begin
                        grant_num_d = winner_others;
                        last_d      = winner_others;
                        hold_cnt_d  = 8'd1;
                    end else begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                    end
                end else if ((MAX_HOLD_C != 8'd0) && (hold_cnt_q >= MAX_HOLD_C) && (|others)) begin
                    grant_num_d = winner_others;
                    last_d      = winner_others;
                    hold_cnt_d  = 8'd1;
                    preempt_d   = 1'b1;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = grant_valid_d ? (4'b0001 << grant_num_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 2'd3;
            hold_cnt_q    <= '0;
            grant_num_q   <= '0;
            grant_valid_q <= 1'b0;
            gnt_q         <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_num_q   <= grant_num_d;
            grant_valid_q <= grant_valid_d;
            gnt_q         <= gnt_d;
            preempt_q     <= preempt_d;
        end
    end

    assign bus_if.grant_num   = grant_num_q;
    assign bus_if.grant_valid = grant_valid_q;
    assign bus_if.gnt         = gnt_q;
    assign bus_if.preempt     = preempt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: two instances (hold limit 4 and disabled) share
// one request stream and are compared every cycle against an ownership model.
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst_n;

    decoder_rr_arbiter_if if_a ();
    decoder_rr_arbiter_if if_b ();

    decoder_rr_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (if_a.slave)
    );

    decoder_rr_arbiter #(.MAX_HOLD(0)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: 0 -> MAX_HOLD=4, 1 -> MAX_HOLD=0
    int m_limit [2] = '{4, 0};
    int m_busy  [2];
    int m_own   [2];
    int m_last  [2];
    int m_hold  [2];
    int m_pre   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_owner(input int mask, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (((mask >> ((base + k) % 4)) & 1) != 0) return (base + k) % 4;
        end
        return base;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_own[i] = 0; m_last[i] = 3; m_hold[i] = 0; m_pre[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int r);
        int rest;
        m_pre[i] = 0;
        if (m_busy[i] == 0) begin
            if (r != 0) begin
                m_own[i]  = next_owner(r, m_last[i]);
                m_last[i] = m_own[i];
                m_hold[i] = 1;
                m_busy[i] = 1;
            end
        end else begin
            rest = r & ~(1 << m_own[i]);
            if (((r >> m_own[i]) & 1) == 0) begin
                if (rest != 0) begin
                    m_own[i]  = next_owner(rest, m_own[i]);
                    m_last[i] = m_own[i];
                    m_hold[i] = 1;
                end else begin
                    m_busy[i] = 0;
                end
            end else if (m_limit[i] != 0 && m_hold[i] >= m_limit[i] && rest != 0) begin
                m_own[i]  = next_owner(rest, m_own[i]);
                m_last[i] = m_own[i];
                m_hold[i] = 1;
                m_pre[i]  = 1;
            end else if (m_hold[i] < 255) begin
                m_hold[i] = m_hold[i] + 1;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int i);
        return (m_busy[i] != 0) ? 4'(1 << m_own[i]) : 4'b0000;
    endfunction

    task automatic compare_all(input string pfx);
        check({pfx, " A.grant_num"},   32'(if_a.grant_num),   32'(m_own[0]));
        check({pfx, " A.grant_valid"}, 32'(if_a.grant_valid), 32'(m_busy[0]));
        check({pfx, " A.gnt"},         32'(if_a.gnt),         32'(exp_gnt(0)));
        check({pfx, " A.preempt"},     32'(if_a.preempt),     32'(m_pre[0]));
        check({pfx, " B.grant_num"},   32'(if_b.grant_num),   32'(m_own[1]));
        check({pfx, " B.grant_valid"}, 32'(if_b.grant_valid), 32'(m_busy[1]));
        check({pfx, " B.gnt"},         32'(if_b.gnt),         32'(exp_gnt(1)));
        check({pfx, " B.preempt"},     32'(if_b.preempt),     32'(m_pre[1]));
    endtask

    // Drive req just after an edge, advance one edge, update model, compare.
    task automatic cycle(input logic [3:0] r, input string pfx);
        if_a.req = r;
        if_b.req = r;
        @(posedge clk);
        model_step(0, int'(r));
        model_step(1, int'(r));
        #1;
        compare_all(pfx);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset(input string pfx);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all({pfx, " async"});
        if_a.req = 4'b0000;
        if_b.req = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n    = 1'b0;
        if_a.req = 4'b0000;
        if_b.req = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // Single request, then drop: grant_num holds at 2.
        cycle(4'b0100, "single");
        check("single num", 32'(if_a.grant_num), 32'd2);
        check("single gnt", 32'(if_a.gnt), 32'b0100);
        cycle(4'b0000, "single drop");
        check("drop num held", 32'(if_a.grant_num), 32'd2);

        // Fair rotation with each owner dropping right after its grant.
        mid_reset("rot");
        cycle(4'b1111, "rot0"); check("rot0 num", 32'(if_a.grant_num), 32'd0);
        cycle(4'b1110, "rot1"); check("rot1 num", 32'(if_a.grant_num), 32'd1);
        cycle(4'b1100, "rot2"); check("rot2 num", 32'(if_a.grant_num), 32'd2);
        cycle(4'b1000, "rot3"); check("rot3 num", 32'(if_a.grant_num), 32'd3);
        cycle(4'b0000, "rot idle");

        // Wrap-around from last=3.
        mid_reset("wrap");
        cycle(4'b1001, "wrap0"); check("wrap0 num", 32'(if_a.grant_num), 32'd0);
        cycle(4'b1000, "wrap3"); check("wrap3 num", 32'(if_a.grant_num), 32'd3);
        cycle(4'b0001, "wrap0b"); check("wrap0b num", 32'(if_a.grant_num), 32'd0);
        cycle(4'b0000, "wrap idle");

        // Preemption: A switches after 4 owned cycles, B holds.
        mid_reset("pre");
        cycle(4'b0001, "pre g");
        repeat (3) cycle(4'b0011, "pre hold");
        check("pre hold A num", 32'(if_a.grant_num), 32'd0);
        cycle(4'b0011, "pre switch");
        check("pre A num", 32'(if_a.grant_num), 32'd1);
        check("pre A pulse", 32'(if_a.preempt), 32'd1);
        check("pre B num", 32'(if_b.grant_num), 32'd0);
        cycle(4'b0011, "pre after");
        check("pre A pulse end", 32'(if_a.preempt), 32'd0);
        repeat (20) cycle(4'b0011, "pre long");
        check("nopre B num", 32'(if_b.grant_num), 32'd0);

        // Release on the timeout cycle wins over preemption.
        mid_reset("relto");
        cycle(4'b0011, "relto g");
        repeat (3) cycle(4'b0011, "relto hold");
        cycle(4'b0010, "relto sw");
        check("relto A num", 32'(if_a.grant_num), 32'd1);
        check("relto A pulse", 32'(if_a.preempt), 32'd0);

        // Reset mid-grant then restart from requester 0.
        mid_reset("mid");
        cycle(4'b0010, "mid g");
        check("mid gnt", 32'(if_a.gnt), 32'b0010);
        mid_reset("mid");
        check("mid rst gnt", 32'(if_a.gnt), 32'b0000);
        check("mid rst num", 32'(if_a.grant_num), 32'd0);
        cycle(4'b1111, "mid restart");
        check("mid restart num", 32'(if_a.grant_num), 32'd0);

        // Random traffic with sticky requests so holds and timeouts occur.
        r = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 199) == 0) mid_reset("rnd");
            else cycle(r, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
